hilo_div_ctrl: RTL and testbench
================================

HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 The block SHALL have ports: reset, synchronous, active-high; clock clock.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 op_valid  in  1  operation request, sampled only in IDLE.
REQ-005 op  in  2  operation: 0 DIV (signed), 1 DIVU, 2 MTHI, 3 MTLO.
REQ-006 rs  in  32  dividend, or MTHI/MTLO source.
REQ-007 rt  in  32  divisor.
REQ-008 busy  out  1  high whenever state is not IDLE.
REQ-009 done  out  1  one-cycle pulse when an operation completes.
REQ-010 div_by_zero  out  1  one-cycle pulse, coincident with done, for DIV/DIVU with rt == 0.
REQ-011 hi, lo  out  32 each  architectural HI/LO registers.
REQ-012 dv_start  out  1  one-cycle start pulse to the iterative unsigned divider.
REQ-013 dv_a, dv_b  out  32 each  unsigned dividend/divisor operands; held stable from START until FIX.
REQ-014 dv_finished  in  1  divider idle/complete flag: drops the edge after start, rises after 32 iterations.
REQ-015 dv_hi, dv_lo  in  32 each  divider remainder/quotient.

Function
REQ-016 The states SHALL be IDLE, START, WAIT, FIX.
REQ-017 IDLE, op_valid high, op in DIV/DIVU, rt != 0: at the sampling edge E0, latch |rs| and |rt| (DIVU: raw values) into dv_a/dv_b, latch sign flags, then go to START.
REQ-018 START SHALL drive dv_start high for exactly one cycle, then go to WAIT at edge E1.
REQ-019 WAIT SHALL ignore dv_finished at E1 and go to FIX on the first later edge where dv_finished == 1; this is E34 with a conforming divider.
REQ-020 FIX SHALL write the sign-corrected dv_lo to lo and dv_hi to hi, return to IDLE, and assert done for the following cycle (edge E35).
REQ-021 Signed correction: quotient is negated when sign(rs) != sign(rt); remainder takes the sign of rs.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0.
REQ-023 DIV/DIVU with rt == 0: no dv_start; hi/lo unchanged; state stays IDLE; done and div_by_zero pulse in the cycle after E0.
REQ-024 MTHI/MTLO: hi or lo is written with rs at E0; state stays IDLE; busy stays low; done pulses in the next cycle.
REQ-025 op_valid while busy SHALL be ignored, with no queueing.
REQ-026 Back-to-back operations: a new op SHALL be accepted in the cycle done is high.
REQ-027 Absolute value and negation SHALL be modulo 2^32, with no saturation.

Reset
REQ-028 Reset SHALL force state IDLE, hi = 0, lo = 0, dv_a = 0, dv_b = 0, dv_start = 0, done = 0, div_by_zero = 0.
REQ-029 Reset mid-operation SHALL abort with no hi/lo write and no done; the divider shares this reset.
REQ-030 Reset SHALL take priority over op_valid in the same cycle.

Structure
REQ-031 A shared package SHALL hold: op encodings (OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO), the state enum, and the DIV_ITER = 32 constant.
REQ-032 One combinational sub-module, div_sign_fix, SHALL implement the abs/negate logic for operands and results.
REQ-033 The divider SHALL be instantiated outside this block and connected through the dv_* ports.

Verification
REQ-034 DIVU rs = 100, rt = 7 -> done 35 cycles after E0; lo = 14, hi = 2; busy high for 34 cycles.
REQ-035 DIV rs = -7 (0xFFFFFFF9), rt = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
REQ-036 DIV rs = 0x80000000, rt = 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-037 DIVU rs = 5, rt = 0 -> next cycle: done = 1, div_by_zero = 1; hi/lo unchanged; dv_start never high.
REQ-038 MTHI 0xDEADBEEF, then DIVU issued at WAIT + 3 (ignored), then reset at WAIT + 10 -> hi = 0, state IDLE, no done pulse.

Source files
------------

// File: rtl/hilo_div_ctrl_pkg.sv
// Shared definitions for the HI/LO divide controller: op encodings, FSM states,
// divider iteration count and a modulo-2^32 negate helper.
package hilo_div_ctrl_pkg;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_MTHI = 2'd2;
    localparam logic [1:0] OP_MTLO = 2'd3;

    localparam int unsigned DIV_ITER = 32;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StFix
    } state_e;

    // Two's-complement negate; wraps, so 0x80000000 maps to itself.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// Connection between the HI/LO controller and the external iterative unsigned
// divider.
interface hilo_div_ctrl_if;

    logic        dv_start;
    logic [31:0] dv_a;
    logic [31:0] dv_b;
    logic        dv_finished;
    logic [31:0] dv_hi;
    logic [31:0] dv_lo;

    modport master (
        output dv_start,
        output dv_a,
        output dv_b,
        input  dv_finished,
        input  dv_hi,
        input  dv_lo
    );

    modport slave (
        input  dv_start,
        input  dv_a,
        input  dv_b,
        output dv_finished,
        output dv_hi,
        output dv_lo
    );

endinterface

// File: rtl/hilo_div_ctrl_div_sign_fix.sv
// Combinational sign handling around the unsigned divider: operand magnitudes
// on the way in, quotient/remainder sign correction on the way out.
module div_sign_fix
    import hilo_div_ctrl_pkg::*;
(
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        is_signed,
    input  logic        quot_neg,
    input  logic        rem_neg,
    input  logic [31:0] dv_hi,
    input  logic [31:0] dv_lo,
    output logic [31:0] abs_a,
    output logic [31:0] abs_b,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    always_comb begin
        abs_a = (is_signed && rs[31]) ? neg32(rs) : rs;
        abs_b = (is_signed && rt[31]) ? neg32(rt) : rt;
        quot  = quot_neg ? neg32(dv_lo) : dv_lo;
        rem   = rem_neg  ? neg32(dv_hi) : dv_hi;
    end

endmodule

// File: rtl/hilo_div_ctrl.sv
// HI/LO register file with MTHI/MTLO and a DIV/DIVU sequencer driving an
// external 32-iteration unsigned divider.
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    hilo_div_ctrl_if.master dv
);

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] dv_a_q, dv_a_d;
    logic [31:0] dv_b_q, dv_b_d;
    logic        dv_start_q, dv_start_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;
    logic        quot_neg_q, quot_neg_d;
    logic        rem_neg_q, rem_neg_d;

    logic        is_signed;
    logic [31:0] abs_a, abs_b, quot, rem;

    assign is_signed = (op == OP_DIV);

    div_sign_fix u_sign_fix (
        .rs        (rs),
        .rt        (rt),
        .is_signed (is_signed),
        .quot_neg  (quot_neg_q),
        .rem_neg   (rem_neg_q),
        .dv_hi     (dv.dv_hi),
        .dv_lo     (dv.dv_lo),
        .abs_a     (abs_a),
        .abs_b     (abs_b),
        .quot      (quot),
        .rem       (rem)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            hi_q       <= '0;
            lo_q       <= '0;
            dv_a_q     <= '0;
            dv_b_q     <= '0;
            dv_start_q <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dv_a_q     <= dv_a_d;
            dv_b_q     <= dv_b_d;
            dv_start_q <= dv_start_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dv_a_d     = dv_a_q;
        dv_b_d     = dv_b_q;
        dv_start_d = 1'b0;
        done_d     = 1'b0;
        dbz_d      = 1'b0;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;

        case (state_q)
            StIdle: begin
                if (op_valid) begin
                    unique case (op)
                        OP_DIV, OP_DIVU: begin
                            if (rt == 32'd0) begin
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                dv_a_d     = abs_a;
                                dv_b_d     = abs_b;
                                quot_neg_d = is_signed && (rs[31] ^ rt[31]);
                                rem_neg_d  = is_signed && rs[31];
                                dv_start_d = 1'b1;
                                state_d    = StStart;
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = rs;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = rs;
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            // dv_finished is still high from the previous idle period here, so
            // it is only looked at once the divider has seen the start pulse.
            StStart: state_d = StWait;
            StWait: begin
                if (dv.dv_finished) state_d = StFix;
            end
            StFix: begin
                lo_d    = quot;
                hi_d    = rem;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dv.dv_start = dv_start_q;
    assign dv.dv_a     = dv_a_q;
    assign dv.dv_b     = dv_b_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed-vector bench for hilo_div_ctrl with a behavioural 32-iteration
// unsigned divider model attached to the dv_* interface.
module tb_hilo_div_ctrl;
    import hilo_div_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;
    int starts = 0;

    hilo_div_ctrl_if dvif ();

    hilo_div_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .op_valid    (op_valid),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .dv          (dvif)
    );

    always #5 clock = ~clock;

    // Divider model: finished drops the edge after start, rises after DIV_ITER edges.
    int unsigned iter_left;
    logic [31:0] m_a, m_b;
    always @(posedge clock) begin
        if (reset) begin
            dvif.dv_finished <= 1'b1;
            dvif.dv_hi       <= '0;
            dvif.dv_lo       <= '0;
            iter_left        <= 0;
        end else if (dvif.dv_start) begin
            dvif.dv_finished <= 1'b0;
            iter_left        <= DIV_ITER;
            m_a              <= dvif.dv_a;
            m_b              <= dvif.dv_b;
        end else if (iter_left != 0) begin
            iter_left <= iter_left - 1;
            if (iter_left == 1) begin
                dvif.dv_finished <= 1'b1;
                dvif.dv_lo       <= (m_b == 0) ? 32'hFFFFFFFF : m_a / m_b;
                dvif.dv_hi       <= (m_b == 0) ? m_a : m_a % m_b;
            end
        end
    end

    always @(posedge clock) if (dvif.dv_start === 1'b1) starts++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents one op for a single edge (E0); returns at the sample just after E0.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        rs       = a;
        rt       = b;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            tick();
            lat++;
            if (!done && !busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_div(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_a,
                           input logic [31:0] exp_b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
        int   lat;
        logic busy_ok;
        issue(o, a, b);
        check_eq({tag, ".busy_e0"}, 32'(busy), 32'd1);
        check_eq({tag, ".start"}, 32'(dvif.dv_start), 32'd1);
        check_eq({tag, ".dv_a"}, dvif.dv_a, exp_a);
        check_eq({tag, ".dv_b"}, dvif.dv_b, exp_b);
        wait_done(lat, busy_ok);
        check_eq({tag, ".latency"}, 32'(lat), 32'd35);
        check_eq({tag, ".busy_held"}, 32'(busy_ok), 32'd1);
        check_eq({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check_eq({tag, ".dbz"}, 32'(div_by_zero), 32'd0);
        check_eq({tag, ".lo"}, lo, exp_lo);
        check_eq({tag, ".hi"}, hi, exp_hi);
        tick();
        check_eq({tag, ".done_drop"}, 32'(done), 32'd0);
    endtask

    initial begin
        int   lat;
        logic busy_ok;
        int   s0;
        logic seen_done, seen_dbz;

        repeat (3) tick();
        check_eq("rst.hi", hi, 32'd0);
        check_eq("rst.lo", lo, 32'd0);
        check_eq("rst.flags", {28'd0, busy, done, div_by_zero, dvif.dv_start}, 32'd0);
        check_eq("rst.dv_a", dvif.dv_a, 32'd0);
        check_eq("rst.dv_b", dvif.dv_b, 32'd0);
        reset = 1'b0;
        tick();

        run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd100, 32'd7, 32'd14, 32'd2);
        run_div("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'd7, 32'd2,
                32'hFFFFFFFD, 32'hFFFFFFFF);
        run_div("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd1,
                32'h80000000, 32'd0);
        run_div("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd2, 32'hFFFFFFFD, 32'd1);
        run_div("div_m7_m2", OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd7, 32'd2,
                32'd3, 32'hFFFFFFFF);
        run_div("divu_max_2", OP_DIVU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd2,
                32'h7FFFFFFF, 32'd1);

        // Divide by zero: immediate done/dbz, nothing else moves.
        s0 = starts;
        issue(OP_DIVU, 32'd5, 32'd0);
        check_eq("dbz.done", 32'(done), 32'd1);
        check_eq("dbz.flag", 32'(div_by_zero), 32'd1);
        check_eq("dbz.busy", 32'(busy), 32'd0);
        check_eq("dbz.hi", hi, 32'd1);
        check_eq("dbz.lo", lo, 32'h7FFFFFFF);
        tick();
        check_eq("dbz.pulse", {30'd0, done, div_by_zero}, 32'd0);
        issue(OP_DIV, 32'hFFFFFFFF, 32'd0);
        check_eq("dbz_s.flag", {30'd0, done, div_by_zero}, 32'd3);
        tick();
        check_eq("dbz.no_start", 32'(starts - s0), 32'd0);

        issue(OP_MTHI, 32'hDEADBEEF, 32'd0);
        check_eq("mthi.done", 32'(done), 32'd1);
        check_eq("mthi.busy", 32'(busy), 32'd0);
        check_eq("mthi.hi", hi, 32'hDEADBEEF);
        check_eq("mthi.lo", lo, 32'h7FFFFFFF);
        tick();

        // Back-to-back: MTLO accepted in the cycle the DIVU's done is high.
        issue(OP_DIVU, 32'd50, 32'd7);
        wait_done(lat, busy_ok);
        check_eq("b2b.latency", 32'(lat), 32'd35);
        op_valid = 1'b1;
        op       = OP_MTLO;
        rs       = 32'hCAFEF00D;
        tick();
        op_valid = 1'b0;
        check_eq("b2b.done", 32'(done), 32'd1);
        check_eq("b2b.lo", lo, 32'hCAFEF00D);
        check_eq("b2b.hi", hi, 32'd1);
        tick();

        // MTHI, then ignored op during WAIT, then reset mid-operation.
        issue(OP_MTHI, 32'hDEADBEEF, 32'd0);
        check_eq("abort.mthi", hi, 32'hDEADBEEF);
        tick();
        s0 = starts;
        issue(OP_DIVU, 32'd100, 32'd7);
        seen_done = 1'b0;
        seen_dbz  = 1'b0;
        tick();
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) begin
                op_valid = 1'b1;
                op       = OP_DIVU;
                rs       = 32'd9;
                rt       = 32'd0;
            end else begin
                op_valid = 1'b0;
            end
            if (i == 10) reset = 1'b1;
            tick();
            seen_done |= done;
            seen_dbz  |= div_by_zero;
        end
        reset = 1'b0;
        check_eq("abort.hi", hi, 32'd0);
        check_eq("abort.lo", lo, 32'd0);
        check_eq("abort.busy", 32'(busy), 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            seen_done |= done;
            seen_dbz  |= div_by_zero;
        end
        check_eq("abort.no_done", 32'(seen_done), 32'd0);
        check_eq("abort.no_dbz", 32'(seen_dbz), 32'd0);
        check_eq("abort.starts", 32'(starts - s0), 32'd1);

        // Reset wins over a simultaneous request.
        op_valid = 1'b1;
        op       = OP_MTHI;
        rs       = 32'hAAAA5555;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        op_valid = 1'b0;
        check_eq("rstprio.hi", hi, 32'd0);
        check_eq("rstprio.done", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
